// File: rtl/mic_pre_pkg.sv
// Shared definitions for the microphone_pre path: channel codes, pairing FSM states
// and the CIC sample width.
package mic_pre_pkg;

  localparam logic        CH_LEFT  = 1'b0;
  localparam logic        CH_RIGHT = 1'b1;
  localparam int unsigned CIC_W    = 32;

  typedef enum logic {
    WAIT_L = 1'b0,
    WAIT_R = 1'b1
  } pair_state_t;

endpackage

// File: rtl/mic_sync_fifo.sv
// Generic single-clock first-word-fall-through FIFO with an occupancy counter.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module mic_sync_fifo #(
  parameter  int unsigned WIDTH = 32,
  parameter  int unsigned DEPTH = 64,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  output logic             full,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty,
  output logic [AW:0]      level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             pop_ok;
  logic             push_ok;

  assign empty   = (level == '0);
  assign full    = (level == (AW+1)'(DEPTH));
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign rd_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/mic_pair_fifo.sv
// Scales/saturates interleaved CIC samples, pairs left+right into {L,R} words and
// queues them in a FWFT FIFO. Define MIC_PAIR_OVF_CNT_EN to add the ovf_cnt output.
module mic_pair_fifo
  import mic_pre_pkg::*;
#(
  parameter  int unsigned SW    = 16,
  parameter  int unsigned DEPTH = 64,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [4:0]       shift,
  input  logic [31:0]      cic_data,
  input  logic             cic_valid,
  input  logic             cic_channel,
  output logic [2*SW-1:0]  rd_data,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic [AW:0]      level,
  output logic             overflow,
  input  logic             clr_ovf,
  output logic             sync_err
`ifdef MIC_PAIR_OVF_CNT_EN
  ,
  output logic [15:0]      ovf_cnt
`endif
);

  localparam logic signed [CIC_W-1:0] SAT_MAX = {{(CIC_W-SW+1){1'b0}}, {(SW-1){1'b1}}};
  localparam logic signed [CIC_W-1:0] SAT_MIN = {{(CIC_W-SW+1){1'b1}}, {(SW-1){1'b0}}};

  logic signed [CIC_W-1:0] shifted;
  logic [SW-1:0]           sat_val;
  logic                    s_valid;
  logic                    s_ch;
  logic [SW-1:0]           s_data;

  always_comb begin
    shifted = $signed(cic_data) >>> shift;
    if (shifted > SAT_MAX)      sat_val = SAT_MAX[SW-1:0];
    else if (shifted < SAT_MIN) sat_val = SAT_MIN[SW-1:0];
    else                        sat_val = shifted[SW-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s_valid <= 1'b0;
      s_ch    <= CH_LEFT;
      s_data  <= '0;
    end else begin
      s_valid <= cic_valid && enable;
      s_ch    <= cic_channel;
      s_data  <= sat_val;
    end
  end

  pair_state_t state, state_nx;
  logic [SW-1:0] l_reg, l_nx;
  logic          push;
  logic          err;

  always_comb begin
    state_nx = state;
    l_nx     = l_reg;
    push     = 1'b0;
    err      = 1'b0;
    if (!enable) begin
      state_nx = WAIT_L;
    end else if (s_valid) begin
      case (state)
        WAIT_L: begin
          if (s_ch == CH_LEFT) begin
            l_nx     = s_data;
            state_nx = WAIT_R;
          end else begin
            err = 1'b1;
          end
        end
        WAIT_R: begin
          if (s_ch == CH_RIGHT) begin
            push     = 1'b1;
            state_nx = WAIT_L;
          end else begin
            // A second left sample replaces the stale one so pairing realigns.
            l_nx = s_data;
            err  = 1'b1;
          end
        end
        default: state_nx = WAIT_L;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= WAIT_L;
      l_reg    <= '0;
      sync_err <= 1'b0;
    end else begin
      state    <= state_nx;
      l_reg    <= l_nx;
      sync_err <= err;
    end
  end

  logic full;
  logic empty;
  logic drop;

  mic_sync_fifo #(
    .WIDTH (2*SW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .wr_data ({l_reg, s_data}),
    .full    (full),
    .pop     (rd_ready),
    .rd_data (rd_data),
    .empty   (empty),
    .level   (level)
  );

  assign rd_valid = !empty;
  assign drop     = push && full && !(rd_valid && rd_ready);

  always_ff @(posedge clk) begin
    if (rst)          overflow <= 1'b0;
    else if (drop)    overflow <= 1'b1;
    else if (clr_ovf) overflow <= 1'b0;
  end

`ifdef MIC_PAIR_OVF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst)                          ovf_cnt <= '0;
    else if (clr_ovf)                 ovf_cnt <= drop ? 16'd1 : 16'd0;
    else if (drop && ovf_cnt != '1)   ovf_cnt <= ovf_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_mic_pair_fifo.sv
// Self-checking bench for mic_pair_fifo: directed scenarios followed by random traffic,
// compared every cycle against a queue-based behavioural model.
module tb_mic_pair_fifo;

  localparam int SW    = 16;
  localparam int DEPTH = 64;
  localparam int AW    = $clog2(DEPTH);

  logic             clk = 1'b0;
  logic             rst;
  logic             enable;
  logic [4:0]       shift;
  logic [31:0]      cic_data;
  logic             cic_valid;
  logic             cic_channel;
  logic [2*SW-1:0]  rd_data;
  logic             rd_valid;
  logic             rd_ready;
  logic [AW:0]      level;
  logic             overflow;
  logic             clr_ovf;
  logic             sync_err;
`ifdef MIC_PAIR_OVF_CNT_EN
  logic [15:0]      ovf_cnt;
`endif

  mic_pair_fifo #(
    .SW    (SW),
    .DEPTH (DEPTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .shift       (shift),
    .cic_data    (cic_data),
    .cic_valid   (cic_valid),
    .cic_channel (cic_channel),
    .rd_data     (rd_data),
    .rd_valid    (rd_valid),
    .rd_ready    (rd_ready),
    .level       (level),
    .overflow    (overflow),
    .clr_ovf     (clr_ovf),
    .sync_err    (sync_err)
`ifdef MIC_PAIR_OVF_CNT_EN
    ,
    .ovf_cnt     (ovf_cnt)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Model: events are the pairing outcomes, due at the edge two after the strobe.
  typedef struct {
    int          cyc;
    bit          push;
    bit          err;
    logic [31:0] word;
  } ev_t;

  ev_t         evq[$];
  logic [31:0] mq[$];
  int          cyc = 0;
  bit          have_l = 0;
  logic [15:0] l_val = '0;
  bit          m_ovf = 0;
  bit          m_sync = 0;
  int          m_cnt = 0;

  function automatic logic [15:0] scale(input logic [31:0] d, input logic [4:0] sh);
    longint v;
    v = longint'($signed(d));
    v = v >>> sh;
    if (v > 32767)  return 16'h7FFF;
    if (v < -32768) return 16'h8000;
    return v[15:0];
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_edge();
    bit pop;
    bit drop;
    cyc++;
    drop = 0;
    if (rst) begin
      evq.delete();
      mq.delete();
      have_l = 0;
      m_ovf  = 0;
      m_sync = 0;
      m_cnt  = 0;
      return;
    end
    if (!enable) have_l = 0;
    pop    = (mq.size() > 0) && rd_ready;
    m_sync = 0;
    if (pop) void'(mq.pop_front());
    if (evq.size() > 0 && evq[0].cyc == cyc) begin
      ev_t e;
      e = evq.pop_front();
      m_sync = e.err;
      if (e.push) begin
        if (mq.size() < DEPTH) mq.push_back(e.word);
        else drop = 1;
      end
    end
    if (drop)         m_ovf = 1;
    else if (clr_ovf) m_ovf = 0;
    if (clr_ovf)      m_cnt = drop ? 1 : 0;
    else if (drop && m_cnt < 65535) m_cnt++;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("rd_valid", 32'(rd_valid), 32'(mq.size() > 0));
    chk("level", 32'(level), 32'(mq.size()));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("sync_err", 32'(sync_err), 32'(m_sync));
    if (mq.size() > 0) chk("rd_data", rd_data, mq[0]);
`ifdef MIC_PAIR_OVF_CNT_EN
    chk("ovf_cnt", 32'(ovf_cnt), 32'(m_cnt));
`endif
  endtask

  task automatic send(input logic ch, input logic [31:0] d, input logic [4:0] sh);
    logic [15:0] sc;
    ev_t e;
    sc = scale(d, sh);
    cic_valid = 1'b1; cic_channel = ch; cic_data = d; shift = sh;
    if (enable) begin
      e.cyc = cyc + 2; e.push = 0; e.err = 0; e.word = '0;
      if (ch == 1'b0) begin
        e.err  = have_l;
        have_l = 1;
        l_val  = sc;
      end else if (have_l) begin
        e.push = 1;
        e.word = {l_val, sc};
        have_l = 0;
      end else begin
        e.err = 1;
      end
      if (e.push || e.err) evq.push_back(e);
    end
    step();
    cic_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    rst = 1'b1; enable = 1'b1; shift = '0; cic_data = '0; cic_valid = 1'b0;
    cic_channel = 1'b0; rd_ready = 1'b0; clr_ovf = 1'b0;
    idle(2);
    rst = 1'b0;
    chk("reset_rd_valid", 32'(rd_valid), 32'd0);
    chk("reset_level", 32'(level), 32'd0);
    chk("reset_overflow", 32'(overflow), 32'd0);
    chk("reset_sync_err", 32'(sync_err), 32'd0);
    chk("reset_rd_data", rd_data, 32'd0);

    // Basic pair
    send(1'b0, 32'h0000_1234, 5'd0);
    send(1'b1, 32'hFFFF_FF00, 5'd0);
    chk("basic_not_yet", 32'(rd_valid), 32'd0);
    step();
    chk("basic_valid", 32'(rd_valid), 32'd1);
    chk("basic_word", rd_data, 32'h1234_FF00);
    chk("basic_level", 32'(level), 32'd1);

    // Saturation
    send(1'b0, 32'h0010_0000, 5'd4);
    send(1'b1, 32'hFFF0_0000, 5'd4);
    rd_ready = 1'b1;
    step();
    rd_ready = 1'b0;
    chk("sat_word", rd_data, 32'h7FFF_8000);
    rd_ready = 1'b1; idle(2); rd_ready = 1'b0;

    // Misordered channels
    send(1'b1, 32'h0000_0009, 5'd0);
    send(1'b0, 32'h0000_0077, 5'd0);
    send(1'b0, 32'h0000_0005, 5'd0);
    send(1'b1, 32'h0000_0006, 5'd0);
    idle(2);
    chk("misorder_level", 32'(level), 32'd1);
    chk("misorder_word", rd_data, 32'h0005_0006);
    rd_ready = 1'b1; idle(2); rd_ready = 1'b0;

    // Overflow: 65 pairs with no reads
    for (int i = 0; i < 65; i++) begin
      send(1'b0, 32'(i + 1), 5'd0);
      send(1'b1, 32'(i + 32'h100), 5'd0);
    end
    idle(2);
    chk("ovf_level", 32'(level), 32'd64);
    chk("ovf_flag", 32'(overflow), 32'd1);
`ifdef MIC_PAIR_OVF_CNT_EN
    chk("ovf_cnt_one", 32'(ovf_cnt), 32'd1);
`endif
    clr_ovf = 1'b1; step(); clr_ovf = 1'b0;
    chk("ovf_cleared", 32'(overflow), 32'd0);

    // Full with simultaneous pop
    send(1'b0, 32'h0000_0AAA, 5'd0);
    send(1'b1, 32'h0000_0BBB, 5'd0);
    rd_ready = 1'b1; step(); rd_ready = 1'b0;
    chk("fullpop_level", 32'(level), 32'd64);
    chk("fullpop_no_ovf", 32'(overflow), 32'd0);
    chk("fullpop_head", rd_data, 32'h0002_0101);
    rd_ready = 1'b1; idle(66); rd_ready = 1'b0;
    chk("drained", 32'(level), 32'd0);

    // Reset between left and right
    send(1'b0, 32'h0000_0111, 5'd0);
    rst = 1'b1; step(); rst = 1'b0;
    send(1'b1, 32'h0000_0222, 5'd0);
    step();
    chk("rstmid_sync_err", 32'(sync_err), 32'd1);
    idle(2);
    chk("rstmid_level", 32'(level), 32'd0);

    // Disabled input is ignored
    enable = 1'b0; idle(3);
    send(1'b0, 32'h0000_0333, 5'd0);
    send(1'b1, 32'h0000_0444, 5'd0);
    idle(3);
    chk("disabled_level", 32'(level), 32'd0);
    enable = 1'b1; idle(3);

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      logic [31:0] d;
      rd_ready = ($urandom_range(0, 3) == 0);
      clr_ovf  = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 3) != 0) begin
        d = $urandom >> $urandom_range(0, 28);
        if ($urandom_range(0, 1) == 1) d = -d;
        send(($urandom_range(0, 5) == 0) ? 1'($urandom_range(0, 1)) : 1'(i % 2),
             d, 5'($urandom_range(0, 20)));
      end else begin
        step();
      end
    end
    clr_ovf = 1'b0;
    rd_ready = 1'b1; idle(70);
    chk("final_level", 32'(level), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mic_pair_fifo.md
Name: mic_pair_fifo

Overview:
Downstream consumer of the CIC decimator output in the microphone_pre path. Takes the interleaved left/right `data_out`/`data_out_valid`/`channel` stream. Scales and saturates each sample to SW bits, then pairs one left and one right sample. Pushes each {L,R} word into a FIFO whose read side uses a valid/ready handshake toward the bus interface.

Parameters:
- SW, 16, output sample width per channel (signed), 8..32.
- DEPTH, 64, FIFO depth in pair words; power of 2, >= 4.
- AW, log2(DEPTH), FIFO address width (derived, localparam).

Ports:
- clk  in  1  system clock; same clock as the CIC block.
- rst  in  1  synchronous, active-high reset.
- enable  in  1  when low, CIC samples are ignored and the pairing FSM is held in WAIT_L.
- shift  in  5  arithmetic right shift applied to the 32b CIC sample before saturation.
- cic_data  in  32  CIC output sample, signed two's complement.
- cic_valid  in  1  one-cycle strobe, sample valid.
- cic_channel  in  1  0 = left, 1 = right.
- rd_data  out  2*SW  {L[SW-1:0], R[SW-1:0]}, first-word-fall-through.
- rd_valid  out  1  FIFO not empty.
- rd_ready  in  1  consumer accepts rd_data when rd_valid && rd_ready.
- level  out  AW+1  current FIFO occupancy, 0..DEPTH.
- overflow  out  1  sticky; set when a pair is dropped.
- clr_ovf  in  1  clears overflow (and ovf_cnt when compiled in).
- sync_err  out  1  one-cycle pulse on a channel-order violation.

Behaviour:
- Reset values: rd_valid=0, level=0, overflow=0, sync_err=0, rd_data=0, FSM=WAIT_L, FIFO pointers=0.
- Scaling stage (registered, 1 cycle):
  - s = cic_data >>> shift (sign-extending).
  - If s > 2^(SW-1)-1, output 2^(SW-1)-1; if s < -2^(SW-1), output -2^(SW-1); otherwise output s[SW-1:0].
  - The stage carries valid and channel alongside the sample.
- Pairing FSM, driven by the scaled strobe:
  - WAIT_L + ch0: latch L, go to WAIT_R.
  - WAIT_L + ch1: drop the sample, pulse sync_err, stay in WAIT_L.
  - WAIT_R + ch1: form {L,R}, issue push, go to WAIT_L.
  - WAIT_R + ch0: overwrite L, pulse sync_err, stay in WAIT_R (resync).
  - enable=0: forces WAIT_L and discards any latched L.
- Latency: a right sample strobed at edge N is scaled at edge N+1 and written at edge N+2. rd_valid is high in the cycle after edge N+2 if the FIFO was empty.
- Push acceptance: push is accepted if level < DEPTH, or if a pop occurs in the same cycle (full with simultaneous pop: both happen, level stays at DEPTH).
  - A refused push drops the pair and sets overflow.
  - The FIFO is never corrupted by a refused push.
- Pop: occurs when rd_valid && rd_ready. Pop on empty is ignored.
- Simultaneous push and pop at level 0: the word is written; rd_valid rises the next cycle; level goes 0→1.
- Pointers wrap modulo DEPTH. level is tracked by a separate counter; full when level == DEPTH.
- clr_ovf and a new overflow in the same cycle: overflow stays 1 (set wins).
- rst mid-operation: FIFO is emptied, latched L is discarded, FSM goes to WAIT_L. The next cycle's cic_valid is processed normally.

Optional Feature:
- MIC_PAIR_OVF_CNT_EN defined:
  - Adds output ovf_cnt[15:0], counting dropped pairs.
  - Saturates at 16'hFFFF; cleared by rst or clr_ovf.
  - When clr_ovf coincides with a drop, the count becomes 1.
- Undefined: the port and counter are absent; overflow behaviour is otherwise identical.

Decomposition:
- Shared package mic_pre_pkg:
  - CH_LEFT=1'b0 and CH_RIGHT=1'b1.
  - Pairing FSM state encoding (WAIT_L, WAIT_R).
  - CIC_W=32.
- One sub-module: mic_sync_fifo.
  - Generic single-clock FWFT FIFO, parameterised width/depth.
  - Ports: push/full, pop/empty, level.
- Scaling and FSM stay in the top.

Test Plan:
1. Basic pair: shift=0, SW=16, L=32'h0000_1234 then R=32'hFFFF_FF00 → one word 32'h1234_FF00; rd_valid high 2 cycles after the R strobe; level=1.
2. Saturation: shift=4, L=32'h0010_0000, R=32'hFFF0_0000 → rd_data=32'h7FFF_8000.
3. Misorder: strobes R,L,L(0x0005),R(0x0006) → sync_err pulses twice; single word 32'h0005_0006.
4. Overflow: rd_ready=0, push 65 pairs with DEPTH=64 → level=64, overflow=1, the 65th pair is absent when drained; ovf_cnt=1 if MIC_PAIR_OVF_CNT_EN.
5. Full + simultaneous pop: level=64, rd_ready=1 in the same cycle as a push → level stays 64, no overflow, read order preserved.
6. Reset mid-pair: L strobed, rst for 1 cycle, then R → no push, sync_err=1; level=0.
